// File: rtl/vga_sync_rx_if.sv
// Video input and recovered-timing bundle for vga_sync_rx.
// master = video source / capture side, slave = timing recovery block.
interface vga_sync_rx_if;
  logic        pix;
  logic        hs_n;
  logic        vs_n;
  logic        blank;
  logic        de;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        line_start;
  logic        frame_start;
  logic [10:0] line_len;
  logic [10:0] frame_lines;
  logic        locked;
  logic        err;

  modport master (
    output pix, hs_n, vs_n, blank,
    input  de, x, y, line_start, frame_start, line_len, frame_lines, locked, err
  );

  modport slave (
    input  pix, hs_n, vs_n, blank,
    output de, x, y, line_start, frame_start, line_len, frame_lines, locked, err
  );
endinterface

// File: rtl/vga_sync_rx.sv
// Receive-side VGA timing recovery: measures line/frame geometry from hs_n/vs_n,
// qualifies lock over consecutive frames and regenerates active-area x/y/de.
module vga_sync_rx #(
  parameter int H_MIN       = 400,
  parameter int H_MAX       = 1023,
  parameter int V_MIN       = 200,
  parameter int V_MAX       = 1023,
  parameter int LOCK_FRAMES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  vga_sync_rx_if.slave vid
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [10:0] H_MIN_C   = 11'(H_MIN);
  localparam logic [10:0] H_MAX_C   = 11'(H_MAX);
  localparam logic [10:0] V_MIN_C   = 11'(V_MIN);
  localparam logic [10:0] V_MAX_C   = 11'(V_MAX);
  localparam logic [2:0]  LOCK_C    = 3'(LOCK_FRAMES);
  localparam logic [10:0] CNT_SAT   = 11'h7FF;
  localparam logic [9:0]  X_SAT     = 10'h3FF;
  localparam logic [8:0]  Y_SAT     = 9'h1FF;

  state_t      state_q, state_d;
  logic        hs_prev_q, hs_prev_d;
  logic        vs_prev_q, vs_prev_d;
  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic [10:0] line_len_q, line_len_d;
  logic [10:0] frame_lines_q, frame_lines_d;
  logic [9:0]  act_x_q, act_x_d;
  logic [8:0]  act_y_q, act_y_d;
  logic        act_seen_q, act_seen_d;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic        de_q, de_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic        locked_q, locked_d;
  logic        err_q, err_d;
  logic [10:0] ref_len_q, ref_len_d;
  logic        ref_valid_q, ref_valid_d;
  logic        bad_frame_q, bad_frame_d;
  logic [2:0]  match_cnt_q, match_cnt_d;
  logic [10:0] prev_lines_q, prev_lines_d;
  logic        have_prev_q, have_prev_d;
  logic [10:0] lock_lines_q, lock_lines_d;

  logic        hs_fall;
  logic        vs_fall;
  logic        line_bad;
  logic        timeout;
  logic        frame_ok;
  logic [9:0]  act_x_cur;
  logic [8:0]  act_y_cur;
  logic        act_seen_cur;

  // Edge qualifiers already include the strobe, so nothing downstream advances on pix=0.
  assign hs_fall  = vid.pix & hs_prev_q & ~vid.hs_n;
  assign vs_fall  = vid.pix & vs_prev_q & ~vid.vs_n;
  assign line_bad = hs_fall & ((h_cnt_q < H_MIN_C) || (h_cnt_q > H_MAX_C) ||
                               (ref_valid_q && (h_cnt_q != ref_len_q)));
  assign timeout  = vid.pix & ~hs_fall & (h_cnt_d > H_MAX_C);

  always_comb begin
    hs_prev_d     = hs_prev_q;
    vs_prev_d     = vs_prev_q;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    act_x_cur     = act_x_q;
    act_y_cur     = act_y_q;
    act_seen_cur  = act_seen_q;
    act_x_d       = act_x_q;
    act_y_d       = act_y_q;
    act_seen_d    = act_seen_q;
    x_d           = x_q;
    y_d           = y_q;
    de_d          = de_q;
    line_start_d  = hs_fall;
    frame_start_d = vs_fall;

    if (vid.pix) begin
      hs_prev_d = vid.hs_n;
      vs_prev_d = vid.vs_n;
      de_d      = ~vid.blank;

      if (hs_fall) begin
        line_len_d = h_cnt_q;
        h_cnt_d    = 11'd1;
      end else if (h_cnt_q != CNT_SAT) begin
        h_cnt_d = h_cnt_q + 11'd1;
      end

      // A line starting on the vs edge belongs to the new frame, so it is counted there.
      if (vs_fall) begin
        frame_lines_d = v_cnt_q;
        v_cnt_d       = {10'd0, hs_fall};
      end else if (hs_fall && (v_cnt_q != CNT_SAT)) begin
        v_cnt_d = v_cnt_q + 11'd1;
      end

      act_x_cur    = hs_fall ? 10'd0 : act_x_q;
      act_y_cur    = vs_fall ? 9'd0 : act_y_q;
      act_seen_cur = vs_fall ? 1'b0 : act_seen_q;
      act_x_d      = act_x_cur;
      act_y_d      = act_y_cur;
      act_seen_d   = act_seen_cur;

      if (!vid.blank) begin
        if (act_x_cur == 10'd0) begin
          if (act_seen_cur && (act_y_cur != Y_SAT)) begin
            act_y_d = act_y_cur + 9'd1;
          end
          act_seen_d = 1'b1;
        end
        if (act_x_cur != X_SAT) begin
          act_x_d = act_x_cur + 10'd1;
        end
        x_d = act_x_cur;
        y_d = act_y_d;
      end else if (vs_fall) begin
        y_d = 9'd0;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ref_len_d    = ref_len_q;
    ref_valid_d  = ref_valid_q;
    bad_frame_d  = bad_frame_q;
    match_cnt_d  = match_cnt_q;
    prev_lines_d = prev_lines_q;
    have_prev_d  = have_prev_q;
    lock_lines_d = lock_lines_q;
    locked_d     = locked_q;
    err_d        = 1'b0;
    frame_ok     = 1'b0;

    case (state_q)
      SEARCH: begin
        locked_d = 1'b0;
        if (vs_fall) begin
          state_d     = ACQUIRE;
          match_cnt_d = 3'd0;
          ref_len_d   = 11'd0;
          ref_valid_d = 1'b0;
          bad_frame_d = 1'b0;
          have_prev_d = 1'b0;
        end
      end

      ACQUIRE: begin
        if (timeout) begin
          state_d     = SEARCH;
          match_cnt_d = 3'd0;
        end else begin
          if (hs_fall && !ref_valid_q) begin
            ref_len_d   = h_cnt_q;
            ref_valid_d = 1'b1;
          end
          if (line_bad) begin
            bad_frame_d = 1'b1;
          end
          if (vs_fall) begin
            frame_ok = !(bad_frame_q || line_bad) &&
                       (v_cnt_q >= V_MIN_C) && (v_cnt_q <= V_MAX_C) &&
                       (!have_prev_q || (v_cnt_q == prev_lines_q));
            prev_lines_d = v_cnt_q;
            have_prev_d  = 1'b1;
            bad_frame_d  = 1'b0;
            if (frame_ok) begin
              match_cnt_d = match_cnt_q + 3'd1;
              if ((match_cnt_q + 3'd1) == LOCK_C) begin
                state_d      = LOCKED;
                locked_d     = 1'b1;
                lock_lines_d = v_cnt_q;
              end
            end else begin
              // Start the reference over so a bad frame cannot seed the next one.
              match_cnt_d = 3'd0;
              ref_valid_d = 1'b0;
            end
          end
        end
      end

      LOCKED: begin
        if ((hs_fall && (h_cnt_q != ref_len_q)) ||
            (vs_fall && (v_cnt_q != lock_lines_q)) || timeout) begin
          err_d       = 1'b1;
          locked_d    = 1'b0;
          state_d     = SEARCH;
          match_cnt_d = 3'd0;
        end
      end

      default: begin
        state_d  = SEARCH;
        locked_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SEARCH;
      hs_prev_q     <= 1'b1;
      vs_prev_q     <= 1'b1;
      h_cnt_q       <= 11'd0;
      v_cnt_q       <= 11'd0;
      line_len_q    <= 11'd0;
      frame_lines_q <= 11'd0;
      act_x_q       <= 10'd0;
      act_y_q       <= 9'd0;
      act_seen_q    <= 1'b0;
      x_q           <= 10'd0;
      y_q           <= 9'd0;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      err_q         <= 1'b0;
      ref_len_q     <= 11'd0;
      ref_valid_q   <= 1'b0;
      bad_frame_q   <= 1'b0;
      match_cnt_q   <= 3'd0;
      prev_lines_q  <= 11'd0;
      have_prev_q   <= 1'b0;
      lock_lines_q  <= 11'd0;
    end else begin
      state_q       <= state_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      act_x_q       <= act_x_d;
      act_y_q       <= act_y_d;
      act_seen_q    <= act_seen_d;
      x_q           <= x_d;
      y_q           <= y_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      err_q         <= err_d;
      ref_len_q     <= ref_len_d;
      ref_valid_q   <= ref_valid_d;
      bad_frame_q   <= bad_frame_d;
      match_cnt_q   <= match_cnt_d;
      prev_lines_q  <= prev_lines_d;
      have_prev_q   <= have_prev_d;
      lock_lines_q  <= lock_lines_d;
    end
  end

  assign vid.de          = de_q;
  assign vid.x           = x_q;
  assign vid.y           = y_q;
  assign vid.line_start  = line_start_q;
  assign vid.frame_start = frame_start_q;
  assign vid.line_len    = line_len_q;
  assign vid.frame_lines = frame_lines_q;
  assign vid.locked      = locked_q;
  assign vid.err         = err_q;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Directed bench for vga_sync_rx using a scaled-down raster (50x16 strobes)
// so several lock/unlock cycles fit in a short run.
module tb_vga_sync_rx;

  localparam int H_TOT = 50;
  localparam int HS_W  = 6;
  localparam int HA0   = 10;
  localparam int HA    = 32;
  localparam int V_TOT = 16;
  localparam int VS_L  = 2;
  localparam int VA0   = 3;
  localparam int VA    = 10;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   div;
  logic s1_ls, s1_fs, s1_err, s2_ls, s2_fs;
  int   err_pulses, err_ln, err_px, err_len;
  bit   lock_seen;
  int   n_err;

  vga_sync_rx_if vif ();

  vga_sync_rx #(
    .H_MIN       (40),
    .H_MAX       (63),
    .V_MIN       (10),
    .V_MAX       (31),
    .LOCK_FRAMES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vid   (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One pixel strobe followed by div-1 idle clocks; pulses are sampled one and two clocks after it.
  task automatic applyStimulus(input logic h, input logic v, input logic b);
    vif.hs_n  = h;
    vif.vs_n  = v;
    vif.blank = b;
    vif.pix   = 1'b1;
    @(posedge clk); #1;
    s1_ls  = vif.line_start;
    s1_fs  = vif.frame_start;
    s1_err = vif.err;
    vif.pix = 1'b0;
    for (int i = 1; i < div; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        s2_ls = vif.line_start;
        s2_fs = vif.frame_start;
      end
    end
  endtask

  task automatic sendLines(input int ln0, input int ln1, input int len, input int stretch_ln, input bit chk);
    int   l_len;
    logic h, v, b;
    for (int ln = ln0; ln <= ln1; ln++) begin
      l_len = (ln == stretch_ln) ? len + 1 : len;
      for (int px = 0; px < l_len; px++) begin
        h = !(px < HS_W);
        v = !(ln < VS_L);
        b = !((ln >= VA0) && (ln < VA0 + VA) && (px >= HA0) && (px < HA0 + HA));
        applyStimulus(h, v, b);
        if (s1_err) begin
          err_pulses++;
          err_ln  = ln;
          err_px  = px;
          err_len = int'(vif.line_len);
        end
        if (vif.locked) lock_seen = 1'b1;
        if (chk) begin
          if (ln == 0 && px == 0) begin
            checkOutput("line_start_pulse", s1_ls, 1);
            checkOutput("frame_start_pulse", s1_fs, 1);
            if (div > 1) begin
              checkOutput("line_start_width", s2_ls, 0);
              checkOutput("frame_start_width", s2_fs, 0);
            end
          end
          if ((ln == VA0 || ln == VA0 + VA - 1) && (px == HA0 || px == HA0 + HA - 1)) begin
            checkOutput("x_active", vif.x, px - HA0);
            checkOutput("y_active", vif.y, ln - VA0);
            checkOutput("de_active", vif.de, 1);
          end
          if (ln == VA0 && px == HA0 + HA) begin
            checkOutput("de_blank", vif.de, 0);
            checkOutput("x_hold", vif.x, HA - 1);
          end
        end
      end
    end
  endtask

  // From SEARCH: three vs falls are needed, lock must appear on the third.
  task automatic runToLock(input bit chk);
    sendLines(0, V_TOT - 1, H_TOT, -1, 1'b0);
    sendLines(0, V_TOT - 1, H_TOT, -1, chk);
    checkOutput("locked_before_3rd_vs", vif.locked, 0);
    sendLines(0, 0, H_TOT, -1, 1'b0);
    checkOutput("locked_at_3rd_vs", vif.locked, 1);
    sendLines(1, V_TOT - 1, H_TOT, -1, 1'b0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    div = 1;
    err_pulses = 0;
    lock_seen = 1'b0;
    vif.pix = 1'b0;
    vif.hs_n = 1'b1;
    vif.vs_n = 1'b1;
    vif.blank = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_de", vif.de, 0);
    checkOutput("rst_x", vif.x, 0);
    checkOutput("rst_y", vif.y, 0);
    checkOutput("rst_line_len", vif.line_len, 0);
    checkOutput("rst_frame_lines", vif.frame_lines, 0);
    checkOutput("rst_locked", vif.locked, 0);
    checkOutput("rst_err", vif.err, 0);
    checkOutput("rst_line_start", vif.line_start, 0);
    rst_n = 1'b1;

    $display("[TB] lock acquisition, pix every clk");
    runToLock(1'b1);
    checkOutput("line_len_nominal", vif.line_len, H_TOT);
    checkOutput("frame_lines_nominal", vif.frame_lines, V_TOT);
    checkOutput("err_idle", vif.err, 0);

    $display("[TB] stretched line while locked");
    err_pulses = 0;
    sendLines(0, V_TOT - 1, H_TOT, 5, 1'b0);
    checkOutput("stretch_err_count", err_pulses, 1);
    checkOutput("stretch_err_line", err_ln, 6);
    checkOutput("stretch_err_px", err_px, 0);
    checkOutput("stretch_line_len", err_len, H_TOT + 1);
    checkOutput("stretch_locked", vif.locked, 0);
    runToLock(1'b0);

    $display("[TB] hs removed while locked");
    n_err = 0;
    for (int k = 1; k <= 40 && n_err == 0; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b1);
      if (s1_err) n_err = k;
    end
    checkOutput("timeout_strobe", n_err, 14);
    checkOutput("timeout_locked", vif.locked, 0);
    checkOutput("timeout_frame_lines", vif.frame_lines, V_TOT);

    $display("[TB] pix 1-in-4 with async reset mid-frame");
    div = 4;
    sendLines(0, 7, H_TOT, -1, 1'b0);
    for (int px = 0; px < 20; px++) begin
      applyStimulus(!(px < HS_W), 1'b1, !(px >= HA0));
    end
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_de", vif.de, 0);
    checkOutput("async_rst_x", vif.x, 0);
    checkOutput("async_rst_line_len", vif.line_len, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("post_rst_line_start", s1_ls, 0);
    checkOutput("post_rst_x", vif.x, 0);
    sendLines(9, V_TOT - 1, H_TOT, -1, 1'b0);
    runToLock(1'b1);
    checkOutput("div4_line_len", vif.line_len, H_TOT);
    checkOutput("div4_frame_lines", vif.frame_lines, V_TOT);

    $display("[TB] short line period");
    div = 1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    err_pulses = 0;
    lock_seen = 1'b0;
    for (int f = 0; f < 4; f++) begin
      sendLines(0, V_TOT - 1, 30, -1, 1'b0);
    end
    checkOutput("short_lock_seen", lock_seen, 0);
    checkOutput("short_err_count", err_pulses, 0);
    checkOutput("short_line_len", vif.line_len, 30);
    checkOutput("short_frame_lines", vif.frame_lines, V_TOT);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
